// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - command constants, row bases and state types for the character-LCD driver
package lcd_pkg;

    localparam logic [7:0] FUNC_8B2L = 8'h38;
    localparam logic [7:0] FUNC_8B1L = 8'h30;
    localparam logic [7:0] FUNC_4B2L = 8'h28;
    localparam logic [7:0] FUNC_4B1L = 8'h20;
    localparam logic [7:0] DISP_ON   = 8'h0C;
    localparam logic [7:0] ENTRY_INC = 8'h06;
    localparam logic [7:0] CLEAR     = 8'h01;
    localparam logic [7:0] DDRAM     = 8'h80;

    // DDRAM address of column 0 for rows 0..3
    localparam logic [3:0][6:0] ROW_BASE = {7'h54, 7'h14, 7'h40, 7'h00};

    typedef enum logic [2:0] {PWRUP, INIT, SCAN, SETADDR, WRDATA} state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_SETUP, TX_EN, TX_HOLD, TX_WAIT} tx_state_t;

    // Init step -> {nibble_only, byte}; 4-bit mode prepends four nibble-only wake-up frames
    function automatic logic [8:0] init_step(input logic [3:0] idx, input logic bus4,
                                             input logic one_row);
        logic [7:0] func;
        logic [3:0] i;
        func = bus4 ? (one_row ? FUNC_4B1L : FUNC_4B2L) : (one_row ? FUNC_8B1L : FUNC_8B2L);
        i = bus4 ? idx - 4'd4 : idx;
        init_step = 9'h000;
        if (bus4 && idx < 4'd4) begin
            init_step = {1'b1, (idx == 4'd3) ? 8'h20 : 8'h30};
        end else begin
            case (i)
                4'd0:    init_step = {1'b0, func};
                4'd1:    init_step = {1'b0, DISP_ON};
                4'd2:    init_step = {1'b0, ENTRY_INC};
                4'd3:    init_step = {1'b0, CLEAR};
                4'd4:    init_step = {1'b0, DDRAM};
                default: init_step = 9'h000;
            endcase
        end
    endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// rtl/lcd_byte_tx.sv - one LCD transfer: setup/enable/hold framing, nibble split, post-clear wait
module lcd_byte_tx
    import lcd_pkg::*;
#(
    parameter int BUS4    = 0,
    parameter int T_SETUP = 10,
    parameter int T_EN    = 50000,
    parameter int T_HOLD  = 10,
    parameter int T_CLEAR = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] tx_byte,
    input  logic       nibble_only,
    input  logic       extra_wait,
    output logic       done,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);

    localparam int TM1  = (T_SETUP > T_EN) ? T_SETUP : T_EN;
    localparam int TM2  = (T_HOLD > T_CLEAR) ? T_HOLD : T_CLEAR;
    localparam int TMAX = (TM1 > TM2) ? TM1 : TM2;
    localparam int TW   = $clog2(TMAX + 1);

    tx_state_t     state, state_nx;
    logic [TW-1:0] timer;
    logic [7:0]    byte_q;
    logic          rs_q, nib_q, xwait_q, low_q, finish, more;

    assign more = (BUS4 != 0) && !low_q && !nib_q;

    // Frame phase register; async reset drops en immediately so no partial strobe completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= TX_IDLE;
        else     state <= state_nx;
    end

    // Phase sequencing: setup -> en -> hold, repeated for the low nibble, then optional clear wait
    always_comb begin
        state_nx = state;
        finish   = 1'b0;
        case (state)
            TX_IDLE:  if (start) state_nx = TX_SETUP;
            TX_SETUP: if (timer == TW'(T_SETUP - 1)) state_nx = TX_EN;
            TX_EN:    if (timer == TW'(T_EN - 1)) state_nx = TX_HOLD;
            TX_HOLD: begin
                if (timer == TW'(T_HOLD - 1)) begin
                    if (more)         state_nx = TX_SETUP;
                    else if (xwait_q) state_nx = TX_WAIT;
                    else begin
                        state_nx = TX_IDLE;
                        finish   = 1'b1;
                    end
                end
            end
            TX_WAIT: begin
                if (timer == TW'(T_CLEAR - 1)) begin
                    state_nx = TX_IDLE;
                    finish   = 1'b1;
                end
            end
            default: state_nx = TX_IDLE;
        endcase
    end

    // Phase timer, latched transfer fields and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer   <= '0;
            byte_q  <= 8'h00;
            rs_q    <= 1'b0;
            nib_q   <= 1'b0;
            xwait_q <= 1'b0;
            low_q   <= 1'b0;
            done    <= 1'b0;
        end else begin
            timer <= (state_nx != state || state == TX_IDLE) ? '0 : timer + 1'b1;
            done  <= finish;
            if (state == TX_IDLE && start) begin
                byte_q  <= tx_byte;
                rs_q    <= rs;
                nib_q   <= nibble_only;
                xwait_q <= extra_wait;
                low_q   <= 1'b0;
            end else if (state == TX_HOLD && state_nx == TX_SETUP) begin
                low_q <= 1'b1;
            end
        end
    end

    assign lcd_en   = (state == TX_EN);
    assign lcd_rs   = rs_q;
    assign lcd_data = (BUS4 != 0) ? {(low_q ? byte_q[3:0] : byte_q[7:4]), 4'h0} : byte_q;

endmodule

// File: rtl/lcd_char_driver_p.sv
// rtl/lcd_char_driver_p.sv - character-LCD driver: power-up, init, cached differential refresh
module lcd_char_driver_p
    import lcd_pkg::*;
#(
    parameter int ROWS    = 2,
    parameter int COLS    = 16,
    parameter int BUS4    = 0,
    parameter int T_PWRUP = 750000,
    parameter int T_SETUP = 10,
    parameter int T_EN    = 50000,
    parameter int T_HOLD  = 10,
    parameter int T_CLEAR = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ROWS*COLS*8-1:0] dis_data,
    input  logic                   force_refresh,
    output logic                   busy,
    output logic                   lcd_rs,
    output logic                   lcd_rw,
    output logic                   lcd_en,
    output logic [7:0]             lcd_data
);

    localparam int N        = ROWS * COLS;
    localparam int CW       = $clog2(N);
    localparam int PW       = $clog2(T_PWRUP + 1);
    localparam int INIT_LEN = (BUS4 != 0) ? 9 : 5;

    state_t              state, state_nx;
    logic [PW-1:0]       pw_timer;
    logic [3:0]          init_idx;
    logic [N-1:0][7:0]   cache;
    logic [CW-1:0]       scan_ptr, cur_addr, m_q, scan_m;
    logic [CW:0]         scan_idx;
    logic                cur_valid, scan_found, refresh_pend, issued;
    logic [7:0]          char_q, tx_byte;
    logic [8:0]          step;
    logic [6:0]          ddram_addr;
    logic                last_col;
    logic                tx_start, tx_rs, tx_nib, tx_xwait, tx_done;

    // Round-robin search for the first cell whose cache differs from the input text
    always_comb begin
        scan_found = 1'b0;
        scan_m     = '0;
        scan_idx   = '0;
        for (int i = 0; i < N; i++) begin
            scan_idx = {1'b0, scan_ptr} + (CW + 1)'(i);
            if (scan_idx >= (CW + 1)'(N)) scan_idx = scan_idx - (CW + 1)'(N);
            if (!scan_found &&
                cache[scan_idx[CW-1:0]] != dis_data[8*scan_idx[CW-1:0] +: 8]) begin
                scan_found = 1'b1;
                scan_m     = scan_idx[CW-1:0];
            end
        end
    end

    // Controller address of the selected cell; rows are not contiguous in DDRAM
    always_comb begin
        ddram_addr = ROW_BASE[2'(int'(m_q) / COLS)] + 7'(int'(m_q) % COLS);
        last_col   = ((int'(m_q) % COLS) == COLS - 1);
    end

    // Main state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= PWRUP;
        else     state <= state_nx;
    end

    // Next-state selection
    always_comb begin
        state_nx = state;
        case (state)
            PWRUP:   if (pw_timer == PW'(T_PWRUP - 1)) state_nx = INIT;
            INIT:    if (tx_done && init_idx == 4'(INIT_LEN - 1)) state_nx = SCAN;
            SCAN:    if (!refresh_pend && scan_found)
                         state_nx = (cur_valid && cur_addr == scan_m) ? WRDATA : SETADDR;
            SETADDR: if (tx_done) state_nx = WRDATA;
            WRDATA:  if (tx_done) state_nx = SCAN;
            default: state_nx = PWRUP;
        endcase
    end

    // Transfer request: one start per INIT step / SETADDR / WRDATA visit
    always_comb begin
        step     = init_step(init_idx, BUS4 != 0, ROWS == 1);
        tx_start = (state == INIT || state == SETADDR || state == WRDATA) && !issued;
        tx_rs    = 1'b0;
        tx_byte  = 8'h00;
        tx_nib   = 1'b0;
        tx_xwait = 1'b0;
        case (state)
            INIT: begin
                tx_byte  = step[7:0];
                tx_nib   = step[8];
                tx_xwait = !step[8] && (step[7:0] == CLEAR);
            end
            SETADDR: tx_byte = DDRAM | {1'b0, ddram_addr};
            WRDATA: begin
                tx_rs   = 1'b1;
                tx_byte = char_q;
            end
            default: tx_byte = 8'h00;
        endcase
    end

    // Timers, cache, scan pointer, address tracking and refresh request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pw_timer     <= '0;
            init_idx     <= 4'd0;
            cache        <= {N{8'h20}};
            scan_ptr     <= '0;
            cur_addr     <= '0;
            cur_valid    <= 1'b0;
            m_q          <= '0;
            char_q       <= 8'h00;
            refresh_pend <= 1'b0;
            issued       <= 1'b0;
        end else begin
            pw_timer <= (state == PWRUP && state_nx == PWRUP) ? pw_timer + 1'b1 : '0;
            if (tx_start)     issued <= 1'b1;
            else if (tx_done) issued <= 1'b0;
            if (state == INIT && tx_done) begin
                init_idx <= init_idx + 1'b1;
                if (init_idx == 4'(INIT_LEN - 1)) begin
                    cur_addr  <= '0;
                    cur_valid <= 1'b1;
                end
            end
            if (state == SCAN && refresh_pend) begin
                cache        <= '0;
                refresh_pend <= force_refresh;
            end else begin
                refresh_pend <= refresh_pend | force_refresh;
                if (state == SCAN && scan_found) begin
                    cache[scan_m] <= dis_data[8*scan_m +: 8];
                    char_q        <= dis_data[8*scan_m +: 8];
                    m_q           <= scan_m;
                end
            end
            if (state == WRDATA && tx_done) begin
                scan_ptr  <= (m_q == CW'(N - 1)) ? '0 : m_q + 1'b1;
                cur_addr  <= m_q + 1'b1;
                cur_valid <= !last_col;
            end
        end
    end

    assign busy   = !(state == SCAN && !scan_found && !refresh_pend);
    assign lcd_rw = 1'b0;

    lcd_byte_tx #(
        .BUS4    (BUS4),
        .T_SETUP (T_SETUP),
        .T_EN    (T_EN),
        .T_HOLD  (T_HOLD),
        .T_CLEAR (T_CLEAR)
    ) u_tx (
        .clk         (clk),
        .rst         (rst),
        .start       (tx_start),
        .rs          (tx_rs),
        .tx_byte     (tx_byte),
        .nibble_only (tx_nib),
        .extra_wait  (tx_xwait),
        .done        (tx_done),
        .lcd_rs      (lcd_rs),
        .lcd_en      (lcd_en),
        .lcd_data    (lcd_data)
    );

endmodule

// File: tb/tb_lcd_char_driver_p.sv
// tb/tb_lcd_char_driver_p.sv - directed bench for the character-LCD driver, 8-bit 2x16 and 4-bit 4x20
module tb_lcd_char_driver_p;

    logic         clk = 1'b0;
    logic         rst0, rst1, fr0, fr1;
    logic [255:0] dis0;
    logic [639:0] dis1;
    logic         busy0, rs0, rw0, en0, busy1, rs1, rw1, en1;
    logic [7:0]   d0, d1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    int         wid0[$];
    int         gap0[$];
    int         rise_last0 = 0;
    int         fall_last0 = -1;
    int         first_rise0 = -1;
    logic       en0_prev = 1'b0;
    logic       en1_prev = 1'b0;
    logic       win = 1'b0;
    logic       busy_drop = 1'b0;

    logic [8:0] e_init0 [0:4]  = '{9'h038, 9'h00C, 9'h006, 9'h001, 9'h080};
    logic [8:0] e_init1 [0:13] = '{9'h030, 9'h030, 9'h030, 9'h020,
                                   9'h020, 9'h080, 9'h000, 9'h0C0, 9'h000,
                                   9'h060, 9'h000, 9'h010, 9'h080, 9'h000};
    logic [8:0] e_a    [0:3]   = '{9'h085, 9'h158, 9'h0C1, 9'h158};
    logic [8:0] e_b    [0:2]   = '{9'h083, 9'h131, 9'h132};
    logic [8:0] e_c    [0:3]   = '{9'h090, 9'h040, 9'h150, 9'h1A0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_char_driver_p #(.ROWS(2), .COLS(16), .BUS4(0), .T_PWRUP(20), .T_SETUP(2),
                        .T_EN(5), .T_HOLD(2), .T_CLEAR(8)) dut0 (
        .clk(clk), .rst(rst0), .dis_data(dis0), .force_refresh(fr0), .busy(busy0),
        .lcd_rs(rs0), .lcd_rw(rw0), .lcd_en(en0), .lcd_data(d0));

    lcd_char_driver_p #(.ROWS(4), .COLS(20), .BUS4(1), .T_PWRUP(20), .T_SETUP(2),
                        .T_EN(5), .T_HOLD(2), .T_CLEAR(8)) dut1 (
        .clk(clk), .rst(rst1), .dis_data(dis1), .force_refresh(fr1), .busy(busy1),
        .lcd_rs(rs1), .lcd_rw(rw1), .lcd_en(en1), .lcd_data(d1));

    always @(negedge clk) begin
        if (en0 && !en0_prev) begin
            q0.push_back({rs0, d0});
            gap0.push_back((fall_last0 < 0) ? -1 : cyc - fall_last0);
            rise_last0 = cyc;
            if (first_rise0 < 0) first_rise0 = cyc;
        end
        if (!en0 && en0_prev) begin
            wid0.push_back(cyc - rise_last0);
            fall_last0 = cyc;
        end
        en0_prev = en0;
        if (en1 && !en1_prev) q1.push_back({rs1, d1});
        en1_prev = en1;
        if (win && !busy0) busy_drop = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qv0(input int i);
        if (i < q0.size()) return 32'(q0[i]);
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] qv1(input int i);
        if (i < q1.size()) return 32'(q1[i]);
        return 32'hDEAD_BEEF;
    endfunction

    function automatic int wv0(input int i);
        if (i < wid0.size()) return wid0[i];
        return -100;
    endfunction

    function automatic int gv0(input int i);
        if (i < gap0.size()) return gap0[i];
        return -100;
    endfunction

    function automatic int data_cnt0();
        int n = 0;
        foreach (q0[i]) if (q0[i][8]) n++;
        return n;
    endfunction

    task automatic wait_idle0(input string tag, input int limit);
        int n = 0;
        repeat (2) @(negedge clk);
        while (busy0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 32'(busy0), 32'd0);
    endtask

    task automatic wait_idle1(input string tag, input int limit);
        int n = 0;
        repeat (2) @(negedge clk);
        while (busy1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 32'(busy1), 32'd0);
    endtask

    initial begin
        int rel;
        int n;
        int sum;
        rst0 = 1'b1;
        rst1 = 1'b1;
        fr0  = 1'b0;
        fr1  = 1'b0;
        dis0 = {32{8'h20}};
        dis1 = {80{8'h20}};
        repeat (3) @(negedge clk);

        check("rst_busy", 32'(busy0), 32'd1);
        check("rst_en", 32'(en0), 32'd0);
        check("rst_rs", 32'(rs0), 32'd0);
        check("rst_data", 32'(d0), 32'd0);
        check("rst_rw", 32'(rw0), 32'd0);
        check("rst_en1", 32'(en1), 32'd0);

        rst0 = 1'b0;
        rst1 = 1'b0;
        rel = cyc;
        first_rise0 = -1;

        wait_idle0("init0", 400);
        check("init0_count", 32'(q0.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("init0_b%0d", i), qv0(i), 32'(e_init0[i]));
            check($sformatf("init0_w%0d", i), 32'(wv0(i)), 32'd5);
        end
        check("pwrup_quiet", 32'((first_rise0 - rel) >= 20), 32'd1);
        check("clear_gap", 32'(gv0(4) >= 8), 32'd1);

        wait_idle1("init1", 1000);
        check("init1_count", 32'(q1.size()), 32'd14);
        for (int i = 0; i < 14; i++)
            check($sformatf("init1_f%0d", i), qv1(i), 32'(e_init1[i]));
        check("rw1", 32'(rw1), 32'd0);

        q0.delete();
        dis0[8*0 +: 8] = 8'h41;
        wait_idle0("cell0", 400);
        check("cell0_count", 32'(q0.size()), 32'd1);
        check("cell0_b0", qv0(0), 32'h141);

        q0.delete();
        dis0[8*5 +: 8]  = 8'h58;
        dis0[8*17 +: 8] = 8'h58;
        wait_idle0("c5_17", 400);
        check("c5_17_count", 32'(q0.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("c5_17_b%0d", i), qv0(i), 32'(e_a[i]));

        q0.delete();
        dis0[8*3 +: 8] = 8'h31;
        dis0[8*4 +: 8] = 8'h32;
        wait_idle0("c3_4", 400);
        check("c3_4_count", 32'(q0.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("c3_4_b%0d", i), qv0(i), 32'(e_b[i]));

        q1.delete();
        dis1[8*40 +: 8] = 8'h5A;
        wait_idle1("c40", 600);
        check("c40_count", 32'(q1.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("c40_f%0d", i), qv1(i), 32'(e_c[i]));

        dis0[8*7 +: 8] = 8'h51;
        n = 0;
        while (!en0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("en_seen", 32'(en0), 32'd1);
        #1 rst0 = 1'b1;
        #1 check("rst_en_async", 32'(en0), 32'd0);
        check("rst_mid_busy", 32'(busy0), 32'd1);
        @(negedge clk);
        check("rst_mid_data", 32'(d0), 32'd0);
        check("rst_mid_rs", 32'(rs0), 32'd0);
        repeat (2) @(negedge clk);
        rst0 = 1'b0;
        wait_idle0("reinit", 1000);

        q0.delete();
        busy_drop = 1'b0;
        fr0 = 1'b1;
        @(negedge clk);
        fr0 = 1'b0;
        check("refresh_busy", 32'(busy0), 32'd1);
        win = 1'b1;
        n = 0;
        while (data_cnt0() < 32 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        win = 1'b0;
        check("refresh_reached32", 32'(data_cnt0()), 32'd32);
        check("refresh_busy_held", 32'(busy_drop), 32'd0);
        wait_idle0("refresh", 400);
        check("refresh_data_count", 32'(data_cnt0()), 32'd32);
        sum = 0;
        foreach (q0[i]) if (q0[i][8]) sum += int'(q0[i][7:0]);
        check("refresh_char_sum", 32'(sum), 32'd1253);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
